fifo_s: RTL and testbench
=========================

Name: fifo_s

Overview:
Single-clock synchronous FIFO with a parameterized data width and depth. It provides full/empty status and a registered read-data output. Write and read requests are gated internally against the status flags: a write to a full FIFO or a read from an empty FIFO has no effect. It is a general-purpose buffer between producer and consumer logic in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits.
DEPTH, 8, number of storage entries; must be a power of two, at least 2.
ADDR, 4, pointer width in bits; equals log2(DEPTH)+1. The extra MSB is the wrap bit used for full/empty detection.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
wen  input  1  write request.
ren  input  1  read request.
data_in  input  WIDTH  write data, sampled on the rising edge of clk.
full  output  1  FIFO holds DEPTH entries.
empty  output  1  FIFO holds 0 entries.
data_out  output  WIDTH  registered read data.

Behaviour:
- Reset is asynchronous and active-low: reset_n=0 immediately clears the pointers, forces data_out=0, empty=1 and full=0. Storage array contents are not reset.
- Reset asserted mid-operation discards all stored data. The FIFO is empty after reset_n is released.
- Pointers: write pointer wp and read pointer rp, each ADDR bits wide. The array index is wp[ADDR-2:0] / rp[ADDR-2:0]. Pointers increment modulo 2^ADDR, so the index wraps naturally.
- Status flags are combinational from the pointers:
  - empty = (wp == rp).
  - full = (wp[ADDR-1] != rp[ADDR-1]) and (lower bits equal).
- Write: on a rising edge with wen=1 and full=0, data_in is stored at mem[wp index] and wp increments.
  - wen=1 while full=1 is ignored: no storage change and no pointer change.
- Read: on a rising edge with ren=1 and empty=0, data_out <= mem[rp index] and rp increments. Latency is one clock from the sampled ren to data_out valid.
  - ren=1 while empty=1 is ignored; data_out holds its last value.
- data_out holds its value whenever no read is accepted.
- Simultaneous wen and ren: each request is qualified by the flags as they stand before the edge.
  - Neither full nor empty: both operations occur and occupancy is unchanged.
  - Empty: only the write occurs. There is no fall-through, so data_out is not updated that cycle.
  - Full: only the read occurs.
- Flags update in the same cycle the pointers change. full asserts immediately after the DEPTH-th accepted write. empty asserts immediately after the last accepted read.
- Order is strict FIFO, with no reordering across pointer wrap-around.

Test Plan:
- Reset: hold reset_n=0 -> empty=1, full=0, data_out=0. Assert reset_n asynchronously between clock edges -> outputs clear without waiting for an edge.
- Fill and overflow: after reset release, wen=1 for 10 consecutive edges with data_in 10,5,6,7,89,125,3,9,22,23.
  - empty deasserts after the first edge.
  - full asserts after the 8th edge.
  - Writes of 22 and 23 are dropped.
- Drain and underflow: from the full state, ren=1 for 10 edges.
  - data_out sequence is 10,5,6,7,89,125,3,9, each one edge after the read.
  - full deasserts after the first read; empty asserts after the 8th read.
  - The remaining reads leave data_out=9.
- Wrap-around: write 5 words, read 5, write 8 words 100..107, then read 8 -> data_out 100..107 in order; full asserts exactly after the 8th write.
- Simultaneous access: with 3 entries stored, wen=ren=1 for 6 edges -> occupancy stays 3, output order is preserved, and both flags stay 0.
  - With the FIFO empty and wen=ren=1: the write is accepted, data_out is unchanged, and empty=0 next.
  - With the FIFO full and wen=ren=1: the read is accepted, the write is dropped, and full=0 next.
- Mid-operation reset: with 4 entries stored, pulse reset_n low -> empty=1, full=0, data_out=0; subsequent reads return only newly written data.

Source files
------------

// File: rtl/fifo_s.sv
// fifo_s: single-clock synchronous FIFO, registered read data.
// Ports: clk, reset_n, wen, ren, data_in -> full, empty, data_out.
module fifo_s #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ADDR  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wen,
  input  logic             ren,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR-1:0]  r_wp;
  logic [ADDR-1:0]  r_rp;
  logic [WIDTH-1:0] r_dout;

  logic [ADDR-2:0]  w_widx;
  logic [ADDR-2:0]  w_ridx;
  logic             w_we;
  logic             w_re;

  assign w_widx = r_wp[ADDR-2:0];
  assign w_ridx = r_rp[ADDR-2:0];

  // Wrap bit differs with equal index: writer is a full lap ahead.
  assign empty = (r_wp == r_rp);
  assign full  = (r_wp[ADDR-1] != r_rp[ADDR-1]) &&
                 (w_widx == w_ridx);

  // Requests qualified by the flags as they stand before the edge.
  assign w_we = wen & ~full;
  assign w_re = ren & ~empty;

  assign data_out = r_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
    end else if (w_we) begin
      r_wp <= r_wp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rp   <= '0;
      r_dout <= '0;
    end else if (w_re) begin
      r_rp   <= r_rp + 1'b1;
      r_dout <= r_mem[w_ridx];
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_widx] <= data_in;
    end
  end

endmodule

// File: tb/tb_fifo_s.sv
// tb_fifo_s: directed checks for fifo_s.
// Vector table for fill/drain, hand sequences for corner cases.
module tb_fifo_s;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic       ef;
    logic       ee;
    logic [7:0] ed;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic [7:0] din = '0;
  logic       full;
  logic       empty;
  logic [7:0] dout;

  int checks = 0;
  int failures = 0;

  vec_t vq[$];

  fifo_s #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wen(wen),
    .ren(ren),
    .data_in(din),
    .full(full),
    .empty(empty),
    .data_out(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic st(input string nm, input logic f, input logic e,
                    input logic [7:0] d);
    chk({nm, ".full"}, {7'd0, full}, {7'd0, f});
    chk({nm, ".empty"}, {7'd0, empty}, {7'd0, e});
    chk({nm, ".dout"}, dout, d);
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wen = w;
    ren = r;
    din = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic add(input logic w, input logic r, input logic [7:0] d,
                     input logic f, input logic e, input logic [7:0] o);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.ef = f; v.ee = e; v.ed = o;
    vq.push_back(v);
  endtask

  initial begin
    logic [7:0] fill [10];
    logic [7:0] last;
    fill = '{8'd10, 8'd5, 8'd6, 8'd7, 8'd89,
             8'd125, 8'd3, 8'd9, 8'd22, 8'd23};

    // Fill and overflow: full after the 8th write.
    for (int i = 0; i < 10; i++)
      add(1'b1, 1'b0, fill[i], (i >= 7), 1'b0, 8'd0);
    // Drain and underflow: data one edge after each read.
    for (int i = 0; i < 10; i++)
      add(1'b0, 1'b1, 8'd0, 1'b0, (i >= 7), fill[(i < 8) ? i : 7]);

    #2;
    st("reset_hold", 1'b0, 1'b1, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    st("post_release", 1'b0, 1'b1, 8'd0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].w, vq[i].r, vq[i].d);
      st($sformatf("vec%0d", i), vq[i].ef, vq[i].ee, vq[i].ed);
    end

    // Wrap-around: offset pointers, then a full lap.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(i + 1));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      chk("wrap_pre_rd", dout, 8'(i + 1));
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'(100 + i));
      chk("wrap_full", {7'd0, full}, {7'd0, (i == 7)});
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      chk("wrap_rd", dout, 8'(100 + i));
    end
    chk("wrap_empty", {7'd0, empty}, 8'd1);

    // Simultaneous with 3 stored.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(200 + i));
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 8'(203 + i));
      st($sformatf("sim%0d", i), 1'b0, 1'b0, 8'(200 + i));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      chk("sim_tail", dout, 8'(206 + i));
    end
    chk("sim_empty", {7'd0, empty}, 8'd1);

    // Simultaneous while empty: only the write happens.
    cyc(1'b1, 1'b1, 8'd50);
    st("sim_e", 1'b0, 1'b0, 8'd208);
    cyc(1'b0, 1'b1, 8'd0);
    st("sim_e_rd", 1'b0, 1'b1, 8'd50);

    // Simultaneous while full: only the read happens.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(60 + i));
    chk("pre_full", {7'd0, full}, 8'd1);
    cyc(1'b1, 1'b1, 8'd99);
    st("sim_f", 1'b0, 1'b0, 8'd60);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      chk("sim_f_rd", dout, 8'(61 + i));
    end
    chk("sim_f_empty", {7'd0, empty}, 8'd1);
    cyc(1'b0, 1'b1, 8'd0);
    chk("underflow_hold", dout, 8'd67);

    // Mid-operation async reset with 4 stored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(70 + i));
    cyc(1'b0, 1'b1, 8'd0);
    st("pre_rst", 1'b0, 1'b0, 8'd70);
    #2;
    reset_n = 1'b0;
    #1;
    st("async_rst", 1'b0, 1'b1, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 8'd80);
    st("after_rst_wr", 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'd0);
    st("after_rst_rd", 1'b0, 1'b1, 8'd80);
    cyc(1'b0, 1'b1, 8'd0);
    st("after_rst_uf", 1'b0, 1'b1, 8'd80);

    last = dout;
    cyc(1'b0, 1'b0, 8'd0);
    chk("idle_hold", dout, last);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
